// File: rtl/imul_mac_seq_pkg.sv
// Shared types and defaults for the sequential multiply-accumulate stage.
package imul_mac_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_OUT    = 2'd2
   } state_t;

   localparam int DEF_SIZE   = 16;
   localparam int DEF_GUARD  = 8;
   localparam int DEF_SETTLE = 2;
   localparam int CNT_W      = 4;

endpackage

// File: rtl/imul_mac_seq_gene.sv
// Combinational unsigned array multiplier: sum of AND-gated, shifted partial products.
module IMUL_GENE #(
   parameter int SIZE = 16
) (
   input  logic [SIZE-1:0]   i_a,
   input  logic [SIZE-1:0]   i_b,
   output logic [2*SIZE-1:0] o_product
);

   logic [2*SIZE-1:0] w_sum;
   logic [2*SIZE-1:0] w_a_ext;

   assign w_a_ext = {{SIZE{1'b0}}, i_a};

   // Ripple partial-product accumulation
   always_comb begin
      w_sum = {(2*SIZE){1'b0}};
      for (int i = 0; i < SIZE; i++) begin
         w_sum = w_sum + ((w_a_ext << i) & {(2*SIZE){i_b[i]}});
      end
   end

   assign o_product = w_sum;

endmodule

// File: rtl/imul_mac_seq.sv
// Multiply-accumulate stage: registers operands, waits SETTLE cycles for the
// array multiplier, then captures product/accumulator behind a valid/ready pair.
module imul_mac_seq
   import imul_mac_seq_pkg::*;
#(
   parameter int SIZE   = DEF_SIZE,
   parameter int GUARD  = DEF_GUARD,
   parameter int SETTLE = DEF_SETTLE
) (
   input  logic                      Clock,
   input  logic                      Reset,
   input  logic                      iValid,
   output logic                      oReady,
   input  logic [SIZE-1:0]           iA,
   input  logic [SIZE-1:0]           iB,
   input  logic                      iAccumulate,
   output logic                      oValid,
   input  logic                      iReady,
   output logic [2*SIZE-1:0]         oProduct,
   output logic [2*SIZE+GUARD-1:0]   oAcc,
   output logic                      oOverflow
);

   localparam int W = 2*SIZE + GUARD;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t              r_state;
   state_t              w_next;
   logic [SIZE-1:0]     r_a;
   logic [SIZE-1:0]     r_b;
   logic                r_acc_flag;
   logic [CNT_W-1:0]    r_cnt;
   logic [2*SIZE-1:0]   r_product;
   logic [W-1:0]        r_acc;
   logic                r_ovf;

   logic [2*SIZE-1:0]   w_product;
   logic [W-1:0]        w_acc_base;
   logic                w_ovf_base;
   logic [W:0]          w_sum;
   logic                w_accept;
   logic                w_capture;

   IMUL_GENE #(.SIZE(SIZE)) u_mul (
      .i_a       (r_a),
      .i_b       (r_b),
      .o_product (w_product)
   );

   assign w_accept  = (r_state == ST_IDLE) && iValid;
   assign w_capture = (r_state == ST_SETTLE) && (r_cnt == CNT_ZERO);

   // A fresh sum discards both the old accumulator and its sticky carry
   always_comb begin
      if (r_acc_flag) begin
         w_acc_base = r_acc;
         w_ovf_base = r_ovf;
      end else begin
         w_acc_base = {W{1'b0}};
         w_ovf_base = 1'b0;
      end
      w_sum = {1'b0, w_acc_base} + {1'b0, W'(w_product)};
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (iValid) w_next = ST_SETTLE;
            else        w_next = ST_IDLE;
         end
         ST_SETTLE: begin
            if (r_cnt == CNT_ZERO) w_next = ST_OUT;
            else                   w_next = ST_SETTLE;
         end
         ST_OUT: begin
            if (iReady) w_next = ST_IDLE;
            else        w_next = ST_OUT;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge Clock) begin
      if (Reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Operand, counter and result registers
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_a        <= {SIZE{1'b0}};
         r_b        <= {SIZE{1'b0}};
         r_acc_flag <= 1'b0;
         r_cnt      <= CNT_ZERO;
         r_product  <= {(2*SIZE){1'b0}};
         r_acc      <= {W{1'b0}};
         r_ovf      <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a        <= iA;
            r_b        <= iB;
            r_acc_flag <= iAccumulate;
            r_cnt      <= CNT_LOAD;
         end else if ((r_state == ST_SETTLE) && (r_cnt != CNT_ZERO)) begin
            r_cnt      <= r_cnt - CNT_ONE;
         end
         if (w_capture) begin
            r_product  <= w_product;
            r_acc      <= w_sum[W-1:0];
            r_ovf      <= w_ovf_base | w_sum[W];
         end
      end
   end

   assign oReady    = (r_state == ST_IDLE);
   assign oValid    = (r_state == ST_OUT);
   assign oProduct  = r_product;
   assign oAcc      = r_acc;
   assign oOverflow = r_ovf;

endmodule

// File: tb/tb_imul_mac_seq.sv
// Scoreboard bench: two instances (GUARD=8 and GUARD=0) share one random stimulus stream.
module tb_imul_mac_seq;

   localparam int SETTLE = 2;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        iValid = 1'b0;
   logic        iAccumulate = 1'b0;
   logic        iReady = 1'b1;
   logic [15:0] iA = 16'd0;
   logic [15:0] iB = 16'd0;

   logic        oReady8, oValid8, ovf8;
   logic [31:0] prod8;
   logic [39:0] acc8;
   logic        oReady0, oValid0, ovf0;
   logic [31:0] prod0;
   logic [31:0] acc0;

   always #5 Clock = ~Clock;

   imul_mac_seq #(.SIZE(16), .GUARD(8), .SETTLE(SETTLE)) u_g8 (
      .Clock(Clock), .Reset(Reset), .iValid(iValid), .oReady(oReady8),
      .iA(iA), .iB(iB), .iAccumulate(iAccumulate), .oValid(oValid8),
      .iReady(iReady), .oProduct(prod8), .oAcc(acc8), .oOverflow(ovf8));

   imul_mac_seq #(.SIZE(16), .GUARD(0), .SETTLE(SETTLE)) u_g0 (
      .Clock(Clock), .Reset(Reset), .iValid(iValid), .oReady(oReady0),
      .iA(iA), .iB(iB), .iAccumulate(iAccumulate), .oValid(oValid0),
      .iReady(iReady), .oProduct(prod0), .oAcc(acc0), .oOverflow(ovf0));

   typedef struct {
      logic [31:0] prod;
      logic [39:0] acc8;
      logic        ovf8;
      logic [31:0] acc0;
      logic        ovf0;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] m_acc8 = 64'd0;
   logic [63:0] m_acc0 = 64'd0;
   logic        m_ovf8 = 1'b0;
   logic        m_ovf0 = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic with explicit modulo per accumulator width
   task automatic model_op(input logic [15:0] a, input logic [15:0] b, input logic acc);
      logic [63:0] p, s8, s0;
      exp_t e;
      p  = 64'(a) * 64'(b);
      s8 = (acc ? m_acc8 : 64'd0) + p;
      s0 = (acc ? m_acc0 : 64'd0) + p;
      m_ovf8 = (acc ? m_ovf8 : 1'b0) | (s8 >= 64'h100_0000_0000);
      m_ovf0 = (acc ? m_ovf0 : 1'b0) | (s0 >= 64'h1_0000_0000);
      m_acc8 = s8 % 64'h100_0000_0000;
      m_acc0 = s0 % 64'h1_0000_0000;
      e.prod = p[31:0];
      e.acc8 = m_acc8[39:0];
      e.ovf8 = m_ovf8;
      e.acc0 = m_acc0[31:0];
      e.ovf0 = m_ovf0;
      sb.push_back(e);
   endtask

   task automatic model_reset();
      sb.delete();
      m_acc8 = 64'd0;
      m_acc0 = 64'd0;
      m_ovf8 = 1'b0;
      m_ovf0 = 1'b0;
   endtask

   // Monitor: compare the head of the scoreboard whenever a result is presented
   always @(negedge Clock) begin
      if (!Reset) begin
         chk("ready_valid_excl", {62'd0, oReady8 & oValid8, oReady0 & oValid0}, 64'd0);
         chk("valid_match", {63'd0, oValid0}, {63'd0, oValid8});
         if (oValid8) begin
            if (sb.size() == 0) begin
               chk("unexpected_valid", 64'd1, 64'd0);
            end else begin
               mon_e = sb[0];
               chk("product8", {32'd0, prod8}, {32'd0, mon_e.prod});
               chk("product0", {32'd0, prod0}, {32'd0, mon_e.prod});
               chk("acc8", {24'd0, acc8}, {24'd0, mon_e.acc8});
               chk("ovf8", {63'd0, ovf8}, {63'd0, mon_e.ovf8});
               chk("acc0", {32'd0, acc0}, {32'd0, mon_e.acc0});
               chk("ovf0", {63'd0, ovf0}, {63'd0, mon_e.ovf0});
               if (iReady) void'(sb.pop_front());
            end
         end
      end
   end

   // Returns 1 once the offered operands are taken at a posedge
   task automatic wait_accept(output logic ok);
      logic rdy;
      int   n;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 20) begin
         @(negedge Clock);
         rdy = oReady8;
         @(posedge Clock);
         if (rdy) ok = 1'b1;
         else     n++;
      end
      if (!ok) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   // Enter and leave at posedge+1
   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic acc, input int hold);
      logic ok;
      int   n;
      iValid = 1'b1; iA = a; iB = b; iAccumulate = acc;
      iReady = (hold == 0);
      wait_accept(ok);
      if (ok) model_op(a, b, acc);
      #1;
      iValid = 1'b0; iA = 16'($urandom); iB = 16'($urandom); iAccumulate = 1'($urandom);
      if (!ok) begin
         iReady = 1'b1;
         return;
      end
      for (int k = 0; k <= SETTLE; k++) begin
         @(negedge Clock);
         chk("latency_valid", {63'd0, oValid8}, {63'd0, k == SETTLE});
      end
      if (hold > 0) begin
         for (int h = 0; h < hold; h++) begin
            @(posedge Clock); #1;
            iValid = 1'b1; iA = 16'($urandom); iB = 16'($urandom);
            @(negedge Clock);
            chk("bp_ready_low", {63'd0, oReady8}, 64'd0);
            chk("bp_valid_held", {63'd0, oValid8}, 64'd1);
         end
         @(posedge Clock); #1;
         iValid = 1'b0; iReady = 1'b1;
         @(negedge Clock);
      end
      n = 0;
      while (!(oValid8 && iReady) && n < 20) begin
         @(negedge Clock);
         n++;
      end
      if (n >= 20) chk("release_timeout", 64'd0, 64'd1);
      @(posedge Clock);
      @(negedge Clock);
      chk("ready_after_release", {63'd0, oReady8}, 64'd1);
      @(posedge Clock); #1;
   endtask

   initial begin
      logic        ok;
      logic [15:0] a, b;
      int          hold;

      // Reset held with random activity on the inputs
      for (int i = 0; i < 3; i++) begin
         @(posedge Clock); #1;
         iValid = 1'($urandom); iA = 16'($urandom); iB = 16'($urandom);
         @(negedge Clock);
         chk("rst_valid", {63'd0, oValid8}, 64'd0);
         chk("rst_acc", {24'd0, acc8}, 64'd0);
         chk("rst_prod", {32'd0, prod8}, 64'd0);
         chk("rst_ovf", {63'd0, ovf8}, 64'd0);
      end
      @(posedge Clock); #1;
      Reset = 1'b0; iValid = 1'b0;
      @(negedge Clock);
      chk("rst_ready", {63'd0, oReady8}, 64'd1);
      @(posedge Clock); #1;

      issue(16'd3, 16'd5, 1'b0, 0);
      chk("new_sum_prod", {32'd0, prod8}, 64'd15);
      chk("new_sum_acc", {24'd0, acc8}, 64'd15);
      issue(16'hFFFF, 16'hFFFF, 1'b1, 0);
      chk("accum_prod", {32'd0, prod8}, 64'h0000_0000_FFFE_0001);
      chk("accum_acc", {24'd0, acc8}, 64'h0000_00FF_FE00_10 >> 0 & 64'hFF_FFFF_FFFF);
      chk("accum_ovf", {63'd0, ovf8}, 64'd0);

      // Wrap on the guard-less instance
      issue(16'hFFFF, 16'hFFFF, 1'b0, 0);
      issue(16'hFFFF, 16'hFFFF, 1'b1, 0);
      chk("wrap_acc0", {32'd0, acc0}, 64'h0000_0000_FFFC_0002);
      chk("wrap_ovf0", {63'd0, ovf0}, 64'd1);
      issue(16'd1, 16'd1, 1'b0, 0);
      chk("clear_acc0", {32'd0, acc0}, 64'd1);
      chk("clear_ovf0", {63'd0, ovf0}, 64'd0);

      issue(16'd1234, 16'd77, 1'b1, 5);

      // Reset one cycle after accept, while settling
      iValid = 1'b1; iA = 16'd9; iB = 16'd9; iAccumulate = 1'b1; iReady = 1'b1;
      wait_accept(ok);
      if (ok) model_op(16'd9, 16'd9, 1'b1);
      #1;
      Reset = 1'b1; iValid = 1'b0;
      model_reset();
      @(posedge Clock); #1;
      Reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clock);
         chk("midrst_no_valid", {63'd0, oValid8}, 64'd0);
      end
      chk("midrst_acc", {24'd0, acc8}, 64'd0);
      @(posedge Clock); #1;
      issue(16'd2, 16'd7, 1'b1, 0);
      chk("midrst_next_acc", {24'd0, acc8}, 64'd14);

      for (int i = 0; i < 40; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         b = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         issue(a, b, ($urandom_range(0, 4) != 0), hold);
      end

      repeat (3) @(posedge Clock);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
      $fatal(1, "watchdog expired");
   end

endmodule
